// File: rtl/counter.sv
// ----------------------------------------------------------------------------
// counter
//
// Synchronous modulo-MODULUS up-counter (decimal by default) with a 4-bit
// binary count and a terminal-count flag. It counts on every rising clock
// edge. Cascade stages at the parent level by feeding CO into the next
// stage's clock-enable logic.
//
// Parameters:
//   MODULUS  count length, legal range 2..16; Q runs 0..MODULUS-1.
//
// Ports:
//   CLK  in   1  clock, all state changes on the rising edge
//   RES  in   1  synchronous active-low reset (0 = reset)
//   Q    out  4  current count, registered
//   CO   out  1  high while Q == MODULUS-1 (decoded from the registered Q)
//   SEG  out  7  {g,f,e,d,c,b,a} active-high segment pattern of Q,
//                present only when COUNTER_SEG7_EN is defined
//
// Build option:
//   COUNTER_SEG7_EN  adds the SEG port and its hex 7-segment decoder.
// ----------------------------------------------------------------------------
module counter #(
    parameter int unsigned MODULUS = 10
) (
    input  logic       CLK,
    input  logic       RES,
    output logic [3:0] Q,
`ifdef COUNTER_SEG7_EN
    output logic       CO,
    output logic [6:0] SEG
`else
    output logic       CO
`endif
);

    localparam logic [3:0] Last = 4'(MODULUS - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Comparing with >= also returns any out-of-range state to 0.
    always_comb begin
        count_d = 4'd0;
        if (count_q < Last) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q  = count_q;
    assign CO = (count_q == Last);

`ifdef COUNTER_SEG7_EN
    always_comb begin
        SEG = 7'h00;
        case (count_q)
            4'h0: SEG = 7'h3F;
            4'h1: SEG = 7'h06;
            4'h2: SEG = 7'h5B;
            4'h3: SEG = 7'h4F;
            4'h4: SEG = 7'h66;
            4'h5: SEG = 7'h6D;
            4'h6: SEG = 7'h7D;
            4'h7: SEG = 7'h07;
            4'h8: SEG = 7'h7F;
            4'h9: SEG = 7'h6F;
            4'hA: SEG = 7'h77;
            4'hB: SEG = 7'h7C;
            4'hC: SEG = 7'h39;
            4'hD: SEG = 7'h5E;
            4'hE: SEG = 7'h79;
            4'hF: SEG = 7'h71;
            default: SEG = 7'h00;
        endcase
    end
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: decimal instance plus MODULUS = 6 and 16.
module tb_counter;

    logic       CLK;
    logic       RES;
    logic [3:0] q10, q6, q16;
    logic       co10, co6, co16;
`ifdef COUNTER_SEG7_EN
    logic [6:0] seg10, seg6, seg16;
`endif

    int n_checks;
    int n_fail;

    counter #(.MODULUS(10)) dut10 (
        .CLK (CLK),
        .RES (RES),
        .Q   (q10),
`ifdef COUNTER_SEG7_EN
        .CO  (co10),
        .SEG (seg10)
`else
        .CO  (co10)
`endif
    );

    counter #(.MODULUS(6)) dut6 (
        .CLK (CLK),
        .RES (RES),
        .Q   (q6),
`ifdef COUNTER_SEG7_EN
        .CO  (co6),
        .SEG (seg6)
`else
        .CO  (co6)
`endif
    );

    counter #(.MODULUS(16)) dut16 (
        .CLK (CLK),
        .RES (RES),
        .Q   (q16),
`ifdef COUNTER_SEG7_EN
        .CO  (co16),
        .SEG (seg16)
`else
        .CO  (co16)
`endif
    );

    // Rising edges at 5, 15, 25, ... ns.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RES = 1'b0;
        step();
        n_checks += 4;
        if (q10 !== 4'd0) begin
            n_fail++; $display("FAIL reset_q10: got %0d want 0", q10);
        end
        if (co10 !== 1'b0) begin
            n_fail++; $display("FAIL reset_co10: got %b want 0", co10);
        end
        if (q6 !== 4'd0) begin
            n_fail++; $display("FAIL reset_q6: got %0d want 0", q6);
        end
        if (q16 !== 4'd0) begin
            n_fail++; $display("FAIL reset_q16: got %0d want 0", q16);
        end
        step();
        n_checks += 2;
        if (q10 !== 4'd0) begin
            n_fail++; $display("FAIL reset_hold_q10: got %0d want 0", q10);
        end
        if (co10 !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold_co10: got %b want 0", co10);
        end
    endtask

    // Release at 23 ns, then 15 edges; all three instances checked per edge.
    task automatic test_count();
        logic [3:0] e10 [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5};
        logic [3:0] e6  [15] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2, 3};
        #(23 - $time);
        RES = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            n_checks += 6;
            if (q10 !== e10[i]) begin
                n_fail++; $display("FAIL count_q10[%0d]: got %0d want %0d", i, q10, e10[i]);
            end
            if (co10 !== (e10[i] == 4'd9)) begin
                n_fail++; $display("FAIL count_co10[%0d]: got %b want %b", i, co10,
                                   (e10[i] == 4'd9));
            end
            if (q6 !== e6[i]) begin
                n_fail++; $display("FAIL count_q6[%0d]: got %0d want %0d", i, q6, e6[i]);
            end
            if (co6 !== (e6[i] == 4'd5)) begin
                n_fail++; $display("FAIL count_co6[%0d]: got %b want %b", i, co6,
                                   (e6[i] == 4'd5));
            end
            if (q16 !== 4'(i + 1)) begin
                n_fail++; $display("FAIL count_q16[%0d]: got %0d want %0d", i, q16, i + 1);
            end
            if (co16 !== (i == 14)) begin
                n_fail++; $display("FAIL count_co16[%0d]: got %b want %b", i, co16, (i == 14));
            end
        end
    endtask

    // Entry state: q10 = 5, q16 = 15.
    task automatic test_wrap();
        step();
        n_checks += 2;
        if (q16 !== 4'd0) begin
            n_fail++; $display("FAIL wrap_q16: got %0d want 0", q16);
        end
        if (co16 !== 1'b0) begin
            n_fail++; $display("FAIL wrap_co16: got %b want 0", co16);
        end
        repeat (3) step();
        n_checks += 2;
        if (q10 !== 4'd9) begin
            n_fail++; $display("FAIL wrap_pre_q10: got %0d want 9", q10);
        end
        if (co10 !== 1'b1) begin
            n_fail++; $display("FAIL wrap_pre_co10: got %b want 1", co10);
        end
        step();
        n_checks += 2;
        if (q10 !== 4'd0) begin
            n_fail++; $display("FAIL wrap_q10: got %0d want 0", q10);
        end
        if (co10 !== 1'b0) begin
            n_fail++; $display("FAIL wrap_co10: got %b want 0", co10);
        end
    endtask

    // Entry state: q10 = 0.
    task automatic test_mid_reset();
        repeat (6) step();
        n_checks += 1;
        if (q10 !== 4'd6) begin
            n_fail++; $display("FAIL mid_pre_q10: got %0d want 6", q10);
        end
        RES = 1'b0;
        step();
        n_checks += 3;
        if (q10 !== 4'd0) begin
            n_fail++; $display("FAIL mid_rst_q10: got %0d want 0", q10);
        end
        if (q6 !== 4'd0) begin
            n_fail++; $display("FAIL mid_rst_q6: got %0d want 0", q6);
        end
        if (q16 !== 4'd0) begin
            n_fail++; $display("FAIL mid_rst_q16: got %0d want 0", q16);
        end
        RES = 1'b1;
        step();
        n_checks += 1;
        if (q10 !== 4'd1) begin
            n_fail++; $display("FAIL mid_rel_q10: got %0d want 1", q10);
        end
    endtask

    // Reset at the terminal value; entry state q10 = 1.
    task automatic test_reset_at_terminal();
        repeat (8) step();
        n_checks += 1;
        if (q10 !== 4'd9) begin
            n_fail++; $display("FAIL term_pre_q10: got %0d want 9", q10);
        end
        RES = 1'b0;
        step();
        n_checks += 2;
        if (q10 !== 4'd0) begin
            n_fail++; $display("FAIL term_rst_q10: got %0d want 0", q10);
        end
        if (co10 !== 1'b0) begin
            n_fail++; $display("FAIL term_rst_co10: got %b want 0", co10);
        end
        RES = 1'b1;
    endtask

`ifdef COUNTER_SEG7_EN
    task automatic test_seg7();
        logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        RES = 1'b0;
        step();
        RES = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks += 1;
            if (seg16 !== pat[i]) begin
                n_fail++; $display("FAIL seg16[%0d]: got %h want %h", i, seg16, pat[i]);
            end
            if (i < 10) begin
                n_checks += 1;
                if (seg10 !== pat[i]) begin
                    n_fail++; $display("FAIL seg10[%0d]: got %h want %h", i, seg10, pat[i]);
                end
            end
            step();
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RES      = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_mid_reset();
        test_reset_at_terminal();
`ifdef COUNTER_SEG7_EN
        test_seg7();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
